// File: rtl/yuv422_ppc_downconv.sv
// Splits each wide YUV422 input beat into IN_PPC/OUT_PPC narrower output beats,
// lowest pixels first, with start-of-frame on the first slice and end-of-line on the last.
module yuv422_ppc_downconv #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_PPC     = 4,
  parameter int OUT_PPC    = 1,
  localparam int RATIO     = IN_PPC / OUT_PPC,
  localparam int CW        = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             s_axis_yuv_tvalid,
  input  logic [DATA_WIDTH*IN_PPC*3-1:0]   s_axis_yuv_tdata,
  input  logic                             s_axis_yuv_tuser,
  input  logic                             s_axis_yuv_tlast,
  output logic                             s_axis_yuv_tready,
  output logic                             m_axis_yuv_tvalid,
  output logic [2*DATA_WIDTH*OUT_PPC-1:0]  m_axis_yuv_tdata,
  output logic                             m_axis_yuv_tuser,
  output logic                             m_axis_yuv_tlast,
  input  logic                             m_axis_yuv_tready,
  output logic [0:0]                       dbg_state,
  output logic [CW-1:0]                    dbg_slice
);

  // Handshake: a beat moves on any rising edge where valid && ready are both high.
  // tready never looks at tvalid on either side; upstream ready is a function of
  // state, slice counter and downstream ready only.

  localparam int HW = 2 * DATA_WIDTH * IN_PPC;
  localparam int OW = 2 * DATA_WIDTH * OUT_PPC;
  localparam int TW = DATA_WIDTH * IN_PPC * 3;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] BUSY  = 1'b1;

  localparam logic [CW-1:0] LAST_SLICE = CW'(RATIO - 1);

  logic [0:0]    state;
  logic [CW-1:0] slice;
  logic [HW-1:0] hold_data;
  logic          hold_user;
  logic          hold_last;

  logic          last_slice;
  logic          in_xfer;
  logic          out_xfer;

  // Bits above the packed pixels carry no information.
  logic unused_tdata_hi;
  assign unused_tdata_hi = ^s_axis_yuv_tdata[TW-1:HW];

  assign last_slice        = (slice == LAST_SLICE);
  assign s_axis_yuv_tready = (state == EMPTY) || (last_slice && m_axis_yuv_tready);
  assign in_xfer           = s_axis_yuv_tvalid && s_axis_yuv_tready;
  assign out_xfer          = (state == BUSY) && m_axis_yuv_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= EMPTY;
      slice     <= '0;
      hold_data <= '0;
      hold_user <= 1'b0;
      hold_last <= 1'b0;
    end else if (in_xfer) begin
      // Covers both the EMPTY load and the bubble-free reload on the last slice.
      state     <= BUSY;
      slice     <= '0;
      hold_data <= s_axis_yuv_tdata[HW-1:0];
      hold_user <= s_axis_yuv_tuser;
      hold_last <= s_axis_yuv_tlast;
    end else if (out_xfer) begin
      if (last_slice) begin
        state <= EMPTY;
        slice <= '0;
      end else begin
        slice <= slice + CW'(1);
      end
    end
  end

  always_comb begin
    m_axis_yuv_tdata = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (slice == CW'(k)) m_axis_yuv_tdata = hold_data[k*OW +: OW];
    end
  end

  assign m_axis_yuv_tvalid = (state == BUSY);
  assign m_axis_yuv_tuser  = (state == BUSY) && hold_user && (slice == '0);
  assign m_axis_yuv_tlast  = (state == BUSY) && hold_last && last_slice;

  assign dbg_state = state;
  assign dbg_slice = slice;

endmodule

// File: tb/tb_yuv422_ppc_downconv.sv
// Directed bench for yuv422_ppc_downconv: vector table at 4:1, streaming with a
// scoreboard, mid-beat reset, and a 4:2 instance with stalls.
module tb_yuv422_ppc_downconv;

  logic        clk;
  logic        aresetn;
  int          cyc;
  int          checks;
  int          errors;

  // 4:1 instance
  logic        s_valid, s_user, s_last, s_ready;
  logic [95:0] s_data;
  logic        m_valid, m_user, m_last, m_ready;
  logic [15:0] m_data;
  logic [0:0]  dbg_state;
  logic [1:0]  dbg_slice;

  // 4:2 instance
  logic        r2_s_valid, r2_s_user, r2_s_last, r2_s_ready;
  logic [95:0] r2_s_data;
  logic        r2_m_valid, r2_m_user, r2_m_last, r2_m_ready;
  logic [31:0] r2_m_data;
  logic [0:0]  r2_dbg_state;
  logic [0:0]  r2_dbg_slice;

  logic [17:0] exp_q[$];

  yuv422_ppc_downconv #(.DATA_WIDTH(8), .IN_PPC(4), .OUT_PPC(1)) dut (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_yuv_tvalid(s_valid), .s_axis_yuv_tdata(s_data),
    .s_axis_yuv_tuser(s_user), .s_axis_yuv_tlast(s_last),
    .s_axis_yuv_tready(s_ready),
    .m_axis_yuv_tvalid(m_valid), .m_axis_yuv_tdata(m_data),
    .m_axis_yuv_tuser(m_user), .m_axis_yuv_tlast(m_last),
    .m_axis_yuv_tready(m_ready),
    .dbg_state(dbg_state), .dbg_slice(dbg_slice)
  );

  yuv422_ppc_downconv #(.DATA_WIDTH(8), .IN_PPC(4), .OUT_PPC(2)) dut_r2 (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_yuv_tvalid(r2_s_valid), .s_axis_yuv_tdata(r2_s_data),
    .s_axis_yuv_tuser(r2_s_user), .s_axis_yuv_tlast(r2_s_last),
    .s_axis_yuv_tready(r2_s_ready),
    .m_axis_yuv_tvalid(r2_m_valid), .m_axis_yuv_tdata(r2_m_data),
    .m_axis_yuv_tuser(r2_m_user), .m_axis_yuv_tlast(r2_m_last),
    .m_axis_yuv_tready(r2_m_ready),
    .dbg_state(r2_dbg_state), .dbg_slice(r2_dbg_slice)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0]      din;
    logic             user;
    logic             last;
    logic [3:0][15:0] exp_d;
    logic [3:0]       exp_u;
    logic [3:0]       exp_l;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_beat(input int b);
    logic [63:0] d;
    for (int p = 0; p < 4; p++) d[16*p +: 16] = {8'h7F, 8'(b * 4 + p)};
    return d;
  endfunction

  task automatic run_stream(input int nbeats, input bit rnd, output int n_out,
                            output int first_c, output int last_c, output int n_sr);
    int          beat;
    int          budget;
    logic        acc;
    logic        prev_stall;
    logic [17:0] prev_out;
    logic [17:0] e;
    beat = 0; budget = 0; prev_stall = 1'b0; prev_out = '0;
    n_out = 0; first_c = -1; last_c = -1; n_sr = 0;
    exp_q.delete();
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = {$urandom(), mk_beat(0)};
    s_user = 1'b1; s_last = (nbeats == 1);
    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while ((beat < nbeats || exp_q.size() != 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
      acc = s_valid && s_ready;
      if (prev_stall) chk("stall_hold", {45'd0, m_valid, m_user, m_last, m_data}, {45'd0, 1'b1, prev_out});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_beat", {46'd0, m_user, m_last, m_data}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("stream_out", {46'd0, m_user, m_last, m_data}, {46'd0, e});
        end
        n_out++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (s_ready) n_sr++;
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_user, m_last, m_data};
      if (acc) begin
        for (int k = 0; k < 4; k++)
          exp_q.push_back({(beat == 0) && (k == 0), (beat == nbeats - 1) && (k == 3),
                           8'h7F, 8'(beat * 4 + k)});
      end
      @(posedge clk); #1;
      if (acc) begin
        beat++;
        if (beat < nbeats) begin
          s_data = {$urandom(), mk_beat(beat)};
          s_user = 1'b0;
          s_last = (beat == nbeats - 1);
        end else begin
          s_valid = 1'b0;
        end
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (budget >= 2000) chk("stream_timeout", 64'(budget), 64'd0);
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    int n_out, first_c, last_c, n_sr;
    checks = 0; errors = 0; cyc = 0;

    vecs[0] = '{64'h7F40_7F30_7F20_7F10, 1'b1, 1'b0,
                {16'h7F40, 16'h7F30, 16'h7F20, 16'h7F10}, 4'b0001, 4'b0000};
    vecs[1] = '{64'h7F40_7F30_7F20_7F10, 1'b0, 1'b1,
                {16'h7F40, 16'h7F30, 16'h7F20, 16'h7F10}, 4'b0000, 4'b1000};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1,
                {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 4'b0001, 4'b1000};
    vecs[3] = '{64'hFFFF_0000_A5A5_0000, 1'b0, 1'b0,
                {16'hFFFF, 16'h0000, 16'hA5A5, 16'h0000}, 4'b0000, 4'b0000};

    aresetn = 1'b0;
    s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    r2_s_valid = 1'b0; r2_s_data = '0; r2_s_user = 1'b0; r2_s_last = 1'b0; r2_m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_user_last", {62'd0, m_user, m_last}, 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_r2_m_valid_data", {31'd0, r2_m_valid, r2_m_data}, 64'd0);
    aresetn = 1'b1;

    // Table: single beats at 4:1 with downstream always ready
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      s_data = {$urandom(), vecs[i].din};
      s_user = vecs[i].user; s_last = vecs[i].last;
      s_valid = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      chk("vec_idle_valid", 64'(m_valid), 64'd0);
      chk("vec_idle_s_ready", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("vec_valid", 64'(m_valid), 64'd1);
        chk("vec_data", 64'(m_data), 64'(vecs[i].exp_d[k]));
        chk("vec_user", 64'(m_user), 64'(vecs[i].exp_u[k]));
        chk("vec_last", 64'(m_last), 64'(vecs[i].exp_l[k]));
      end
    end

    // Continuous stream, downstream always ready
    run_stream(8, 1'b0, n_out, first_c, last_c, n_sr);
    chk("cont_out_count", 64'(n_out), 64'd32);
    chk("cont_no_gaps", 64'(last_c - first_c), 64'd31);
    chk("cont_s_ready_count", 64'(n_sr), 64'd8);

    // Random downstream backpressure
    run_stream(12, 1'b1, n_out, first_c, last_c, n_sr);
    chk("rand_out_count", 64'(n_out), 64'd48);

    // Mid-beat reset discards remaining slices
    @(posedge clk); #1;
    s_data = {32'h0, 64'h7F44_7F33_7F22_7F11}; s_user = 1'b0; s_last = 1'b1;
    s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("rst_seq_slice0", 64'(m_data), 64'h7F11);
    @(negedge clk);
    chk("rst_seq_slice1", 64'(m_data), 64'h7F22);
    @(posedge clk); #1;
    aresetn = 1'b0;
    #1;
    chk("rst_seq_valid", 64'(m_valid), 64'd0);
    chk("rst_seq_outputs", {46'd0, m_user, m_last, m_data}, 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    s_data = {32'hFFFF_FFFF, 64'h7F04_7F03_7F02_7F01}; s_user = 1'b1; s_last = 1'b0;
    s_valid = 1'b1;
    #1;
    chk("rst_seq_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_seq_new", {46'd0, m_valid, m_user, m_data}, {46'd0, 1'b1, k == 0, 8'h7F, 8'(k + 1)});
    end
    @(negedge clk);
    chk("rst_seq_drained", 64'(m_valid), 64'd0);

    // 4:2 instance with a stall on each slice
    @(posedge clk); #1;
    r2_s_data = {32'h1234_5678, 64'h7F40_7F30_7F20_7F10}; r2_s_user = 1'b1; r2_s_last = 1'b1;
    r2_s_valid = 1'b1; r2_m_ready = 1'b1;
    @(posedge clk); #1;
    r2_s_valid = 1'b0; r2_m_ready = 1'b0;
    @(negedge clk);
    chk("r2_slice0", {29'd0, r2_m_valid, r2_m_user, r2_m_last, r2_m_data}, {29'd0, 3'b110, 32'h7F20_7F10});
    chk("r2_slice0_s_ready", 64'(r2_s_ready), 64'd0);
    @(posedge clk); #1;
    r2_m_ready = 1'b1;
    @(negedge clk);
    chk("r2_slice0_held", {29'd0, r2_m_valid, r2_m_user, r2_m_last, r2_m_data}, {29'd0, 3'b110, 32'h7F20_7F10});
    chk("r2_mid_s_ready", 64'(r2_s_ready), 64'd0);
    @(negedge clk);
    chk("r2_slice1", {29'd0, r2_m_valid, r2_m_user, r2_m_last, r2_m_data}, {29'd0, 3'b101, 32'h7F40_7F30});
    chk("r2_last_s_ready_hi", 64'(r2_s_ready), 64'd1);
    r2_m_ready = 1'b0;
    #1;
    chk("r2_last_s_ready_lo", 64'(r2_s_ready), 64'd0);
    @(posedge clk); #1;
    r2_m_ready = 1'b1;
    @(negedge clk);
    chk("r2_slice1_held", 64'(r2_m_data), 64'h7F40_7F30);
    @(negedge clk);
    chk("r2_drained", 64'(r2_m_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
